// File: rtl/sfu_pkg.sv
// Shared types and helpers for the accumulate/ReLU/shift SFU.
// Build option: define SFU_SAT_EN to saturate results instead of wrapping them.
package sfu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        ACT  = 2'd2,
        HOLD = 2'd3
    } state_t;

`ifdef SFU_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    function automatic int unsigned acc_bw(input int unsigned psum_bw,
                                           input int unsigned acc_cnt_bw);
        return psum_bw + acc_cnt_bw;
    endfunction

    // Returns {below_min, above_max} for a bw-bit signed target; all-zero when wrapping.
    function automatic logic [1:0] lane_clip(input logic signed [63:0] v,
                                             input int unsigned       bw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (bw - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return SAT_EN ? {(v < lo), (v > hi)} : 2'b00;
    endfunction

endpackage

// File: rtl/sfu_acc_pipe_if.sv
// Handshake, configuration and data bundle of the SFU (SFU_SAT_EN does not affect it).
interface sfu_acc_pipe_if #(
    parameter int unsigned PSUM_BW    = 16,
    parameter int unsigned COL        = 8,
    parameter int unsigned ACC_CNT_BW = 8,
    parameter int unsigned SHIFT_BW   = 4
);
    logic                      start;
    logic [ACC_CNT_BW-1:0]     cfg_num_acc;
    logic                      cfg_relu_en;
    logic [PSUM_BW-1:0]        cfg_thres;
    logic [SHIFT_BW-1:0]       cfg_shift;
    logic                      in_valid;
    logic                      in_ready;
    logic [PSUM_BW*COL-1:0]    in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [PSUM_BW*COL-1:0]    out_data;
    logic                      busy;

    modport master (
        output start, cfg_num_acc, cfg_relu_en, cfg_thres, cfg_shift,
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  start, cfg_num_acc, cfg_relu_en, cfg_thres, cfg_shift,
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/sfu_lane.sv
// One SFU lane: guarded accumulator, threshold ReLU, arithmetic shift, wrap or clip.
// Build option: SFU_SAT_EN (via sfu_pkg) selects saturation instead of wrap.
module sfu_lane
    import sfu_pkg::*;
#(
    parameter int unsigned PSUM_BW    = 16,
    parameter int unsigned ACC_CNT_BW = 8,
    parameter int unsigned SHIFT_BW   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,
    input  logic                acc_en,
    input  logic                act_en,
    input  logic [PSUM_BW-1:0]  in_lane,
    input  logic                relu_en,
    input  logic [PSUM_BW-1:0]  thres,
    input  logic [SHIFT_BW-1:0] shift,
    output logic [PSUM_BW-1:0]  res
);
    localparam int unsigned ACC_BW = acc_bw(PSUM_BW, ACC_CNT_BW);

    logic signed [ACC_BW-1:0] r_acc;
    logic [PSUM_BW-1:0]       r_res;
    logic signed [ACC_BW-1:0] w_in_ext;
    logic signed [ACC_BW-1:0] w_thres_ext;
    logic signed [ACC_BW-1:0] w_relu;
    logic signed [ACC_BW-1:0] w_shr;
    logic signed [63:0]       w_wide;
    logic [1:0]               w_sel;
    logic [PSUM_BW-1:0]       w_final;

    assign w_in_ext    = {{ACC_CNT_BW{in_lane[PSUM_BW-1]}}, in_lane};
    assign w_thres_ext = {{ACC_CNT_BW{thres[PSUM_BW-1]}}, thres};

    always_comb begin
        w_relu = r_acc;
        if (relu_en && !(r_acc > w_thres_ext)) begin
            w_relu = '0;
        end
    end

    assign w_shr  = w_relu >>> shift;
    assign w_wide = {{(64-ACC_BW){w_shr[ACC_BW-1]}}, w_shr};
    assign w_sel  = lane_clip(w_wide, PSUM_BW);

    always_comb begin
        case (w_sel)
            2'b01:   w_final = {1'b0, {(PSUM_BW-1){1'b1}}};
            2'b10:   w_final = {1'b1, {(PSUM_BW-1){1'b0}}};
            default: w_final = w_shr[PSUM_BW-1:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= '0;
            r_res <= '0;
        end else begin
            if (clr) begin
                r_acc <= '0;
            end else if (acc_en) begin
                r_acc <= r_acc + w_in_ext;
            end
            if (act_en) begin
                r_res <= w_final;
            end
        end
    end

    assign res = r_res;
endmodule

// File: rtl/sfu_acc_pipe.sv
// Multi-lane accumulate / ReLU / shift SFU between psum SRAM and output SRAM.
// Build option: define SFU_SAT_EN to saturate lane results instead of wrapping.
module sfu_acc_pipe
    import sfu_pkg::*;
#(
    parameter int unsigned PSUM_BW    = 16,
    parameter int unsigned COL        = 8,
    parameter int unsigned ACC_CNT_BW = 8,
    parameter int unsigned SHIFT_BW   = 4
) (
    input  logic           clk,
    input  logic           reset,
    sfu_acc_pipe_if.slave  bus
);
    state_t                r_state;
    state_t                w_next;
    logic [ACC_CNT_BW-1:0] r_count;
    logic [ACC_CNT_BW-1:0] r_num_acc;
    logic                  r_relu_en;
    logic [PSUM_BW-1:0]    r_thres;
    logic [SHIFT_BW-1:0]   r_shift;

    logic                  w_start;
    logic                  w_beat;
    logic                  w_last;
    logic [COL-1:0][PSUM_BW-1:0] w_res;

    assign w_start = (r_state == IDLE) && bus.start;
    assign w_beat  = (r_state == ACC) && bus.in_valid;
    assign w_last  = w_beat && (r_count == r_num_acc - 1'b1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start)     w_next = ACC;
            ACC:     if (w_last)        w_next = ACT;
            ACT:                        w_next = HOLD;
            HOLD:    if (bus.out_ready) w_next = IDLE;
            default:                    w_next = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (r_state == ACC);
        bus.out_valid = (r_state == HOLD);
        bus.busy      = (r_state != IDLE);
    end

    // A zero count is stored as one so the last-beat compare never underflows.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count   <= '0;
            r_num_acc <= '0;
            r_relu_en <= 1'b0;
            r_thres   <= '0;
            r_shift   <= '0;
        end else if (w_start) begin
            r_count   <= '0;
            r_num_acc <= (bus.cfg_num_acc == '0) ? ACC_CNT_BW'(1) : bus.cfg_num_acc;
            r_relu_en <= bus.cfg_relu_en;
            r_thres   <= bus.cfg_thres;
            r_shift   <= bus.cfg_shift;
        end else if (w_beat) begin
            r_count   <= r_count + 1'b1;
        end
    end

    for (genvar c = 0; c < COL; c++) begin : g_lane
        sfu_lane #(
            .PSUM_BW    (PSUM_BW),
            .ACC_CNT_BW (ACC_CNT_BW),
            .SHIFT_BW   (SHIFT_BW)
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .clr     (w_start),
            .acc_en  (w_beat),
            .act_en  (r_state == ACT),
            .in_lane (bus.in_data[PSUM_BW*c +: PSUM_BW]),
            .relu_en (r_relu_en),
            .thres   (r_thres),
            .shift   (r_shift),
            .res     (w_res[c])
        );
    end

    assign bus.out_data = w_res;
endmodule

// File: tb/tb_sfu_acc_pipe.sv
// Directed bench for sfu_acc_pipe; expectations follow SFU_SAT_EN when it is defined.
module tb_sfu_acc_pipe;
    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    sfu_acc_pipe_if #(.PSUM_BW(16), .COL(8), .ACC_CNT_BW(8), .SHIFT_BW(4)) bus ();

    sfu_acc_pipe #(.PSUM_BW(16), .COL(8), .ACC_CNT_BW(8), .SHIFT_BW(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [127:0] pk(input int a0, input int a1, input int a2, input int a3,
                                        input int a4, input int a5, input int a6, input int a7);
        return {16'(a7), 16'(a6), 16'(a5), 16'(a4), 16'(a3), 16'(a2), 16'(a1), 16'(a0)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_lane(input string tag, input int idx, input int exp);
        logic [15:0] e;
        e = 16'(exp);
        chk(tag, {16'h0, bus.out_data[16*idx +: 16]}, {16'h0, e});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int num, input logic relu, input int thres, input int shift);
        bus.start       = 1'b1;
        bus.cfg_num_acc = 8'(num);
        bus.cfg_relu_en = relu;
        bus.cfg_thres   = 16'(thres);
        bus.cfg_shift   = 4'(shift);
        tick();
        bus.start = 1'b0;
    endtask

    task automatic send(input logic [127:0] d);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        chk("send_ready", {31'h0, bus.in_ready}, 32'h1);
        tick();
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
    endtask

    task automatic wait_result();
        int n;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
        chk("result_valid", {31'h0, bus.out_valid}, 32'h1);
    endtask

    task automatic accept();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("accept_valid_low", {31'h0, bus.out_valid}, 32'h0);
        chk("accept_idle", {31'h0, bus.busy}, 32'h0);
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.cfg_num_acc = '0; bus.cfg_relu_en = 1'b0;
        bus.cfg_thres = '0; bus.cfg_shift = '0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_in_ready", {31'h0, bus.in_ready}, 32'h0);
        chk("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
        chk("rst_busy", {31'h0, bus.busy}, 32'h0);
        chk("rst_data_lo", bus.out_data[31:0], 32'h0);
        chk("rst_data_hi", bus.out_data[127:96], 32'h0);

        // in_valid while idle must not contribute to the next accumulation
        bus.in_valid = 1'b1; bus.in_data = pk(1000, 1000, 0, 0, 0, 0, 0, 1000);
        chk("idle_in_ready", {31'h0, bus.in_ready}, 32'h0);
        tick(); tick();
        bus.in_valid = 1'b0; bus.in_data = '0;

        // 1: three beats, plain sum, latency
        do_start(3, 1'b0, 0, 0);
        chk("t1_busy", {31'h0, bus.busy}, 32'h1);
        send(pk(10, 0, 0, 0, 0, 0, 0, -1));
        send(pk(-4, 0, 0, 0, 0, 0, 0, -1));
        send(pk(7, 0, 0, 0, 0, 0, 0, -1));
        chk("t1_lat_act", {31'h0, bus.out_valid}, 32'h0);
        chk("t1_act_in_ready", {31'h0, bus.in_ready}, 32'h0);
        tick();
        chk("t1_lat_hold", {31'h0, bus.out_valid}, 32'h1);
        chk_lane("t1_lane0", 0, 13);
        chk_lane("t1_lane1", 1, 0);
        chk_lane("t1_lane7", 7, -3);
        accept();

        // 2a: ReLU at threshold 0
        do_start(1, 1'b1, 0, 0);
        send(pk(-5, 0, 1, -100, 200, 0, 0, 0));
        wait_result();
        chk_lane("t2a_neg", 0, 0);
        chk_lane("t2a_zero", 1, 0);
        chk_lane("t2a_one", 2, 1);
        chk_lane("t2a_big_neg", 3, 0);
        chk_lane("t2a_pos", 4, 200);
        accept();

        // 2b: ReLU at threshold 5, strict compare
        do_start(1, 1'b1, 5, 0);
        send(pk(5, 6, -3, 0, 0, 0, 0, 0));
        wait_result();
        chk_lane("t2b_eq", 0, 0);
        chk_lane("t2b_above", 1, 6);
        chk_lane("t2b_neg", 2, 0);
        accept();

        // 2c: negative threshold keeps negative values above it
        do_start(1, 1'b1, -10, 0);
        send(pk(-5, -10, -11, 0, 0, 0, 0, 0));
        wait_result();
        chk_lane("t2c_above", 0, -5);
        chk_lane("t2c_eq", 1, 0);
        chk_lane("t2c_below", 2, 0);
        accept();

        // 3: arithmetic shift
        do_start(1, 1'b0, 0, 2);
        send(pk(13, -13, 0, 0, 0, 0, 0, 0));
        wait_result();
        chk_lane("t3_pos", 0, 3);
        chk_lane("t3_neg", 1, -4);
        accept();
        do_start(1, 1'b0, 0, 15);
        send(pk(-1, 32767, 0, 0, 0, 0, 0, 0));
        wait_result();
        chk_lane("t3_max_neg", 0, -1);
        chk_lane("t3_max_pos", 1, 0);
        accept();

        // 4: overflow beyond the lane width
        do_start(2, 1'b0, 0, 0);
        send(pk(30000, -30000, 0, 0, 0, 0, 0, 0));
        send(pk(30000, -30000, 0, 0, 0, 0, 0, 0));
        wait_result();
`ifdef SFU_SAT_EN
        chk_lane("t4_pos_ovf", 0, 32767);
        chk_lane("t4_neg_ovf", 1, -32768);
`else
        chk_lane("t4_pos_ovf", 0, -5536);
        chk_lane("t4_neg_ovf", 1, 5536);
`endif
        accept();

        // 5: hold under backpressure, start ignored while busy
        do_start(1, 1'b0, 0, 0);
        send(pk(42, 0, 0, 0, 0, 0, 0, 0));
        wait_result();
        for (int i = 0; i < 5; i++) begin
            bus.start       = (i == 2);
            bus.cfg_num_acc = 8'd5;
            chk("t5_hold_valid", {31'h0, bus.out_valid}, 32'h1);
            chk("t5_hold_ready", {31'h0, bus.in_ready}, 32'h0);
            chk_lane("t5_hold_data", 0, 42);
            tick();
        end
        bus.start = 1'b0;
        accept();
        chk_lane("t5_data_kept", 0, 42);

        // num_acc = 0 acts as one beat
        do_start(0, 1'b0, 0, 0);
        send(pk(77, 0, 0, 0, 0, 0, 0, 0));
        tick();
        chk("t_num0_valid", {31'h0, bus.out_valid}, 32'h1);
        chk_lane("t_num0_data", 0, 77);
        accept();

        // stalls between beats and cfg changes after start have no effect
        do_start(3, 1'b0, 0, 0);
        send(pk(1, 0, 0, 0, 0, 0, 0, 0));
        bus.cfg_shift = 4'd3; bus.cfg_relu_en = 1'b1; bus.cfg_thres = 16'd100;
        tick(); tick();
        send(pk(2, 0, 0, 0, 0, 0, 0, 0));
        tick();
        send(pk(3, 0, 0, 0, 0, 0, 0, 0));
        wait_result();
        chk_lane("t_gap_sum", 0, 6);
        accept();

        // 6: reset mid-accumulation drops partial state
        do_start(3, 1'b0, 0, 0);
        send(pk(100, 0, 0, 0, 0, 0, 0, 0));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_busy", {31'h0, bus.busy}, 32'h0);
        chk("t6_out_valid", {31'h0, bus.out_valid}, 32'h0);
        chk("t6_in_ready", {31'h0, bus.in_ready}, 32'h0);
        chk("t6_data", bus.out_data[31:0], 32'h0);
        do_start(2, 1'b0, 0, 0);
        send(pk(4, 0, 0, 0, 0, 0, 0, 0));
        send(pk(4, 0, 0, 0, 0, 0, 0, 0));
        wait_result();
        chk_lane("t6_after_reset", 0, 8);
        accept();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
